// File: rtl/pipe_ctrl_pkg.sv
// lc3b pipeline control types: forwarding selects,
// controller FSM states and the per-stage record.
package lc3b_types;

  localparam int LC3B_REG_W = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } pipe_state_t;

  typedef struct packed {
    logic                  v;
    logic [LC3B_REG_W-1:0] dest;
    logic                  ld_reg;
    logic                  is_load;
  } stage_rec_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> pipeline controller bundle.
// master: datapath (drives ID info, stalls, redirect);
// slave: controller (drives enables, valids, fwd selects, counters).
interface pipe_ctrl_if #(
  parameter int REG_W = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 32
);
  logic [NSRC*REG_W-1:0] id_src;
  logic [NSRC-1:0]       id_src_used;
  logic [REG_W-1:0]      id_dest;
  logic                  id_ld_reg;
  logic                  id_is_load;
  logic                  i_stall;
  logic                  d_stall;
  logic                  redirect;

  logic                  load_if;
  logic                  load_id_ex;
  logic                  load_ex_mem;
  logic                  load_mem_wb;
  logic                  valid_ex;
  logic                  valid_mem;
  logic                  valid_wb;
  logic [2*NSRC-1:0]     fwd_sel_ex;
  logic                  stall_load;
  logic [CNT_W-1:0]      cnt_load_stall;
  logic [CNT_W-1:0]      cnt_flush;
  logic [CNT_W-1:0]      cnt_istall;

  modport master (
    output id_src, id_src_used, id_dest,
    output id_ld_reg, id_is_load,
    output i_stall, d_stall, redirect,
    input  load_if, load_id_ex,
    input  load_ex_mem, load_mem_wb,
    input  valid_ex, valid_mem, valid_wb,
    input  fwd_sel_ex, stall_load,
    input  cnt_load_stall, cnt_flush, cnt_istall
  );

  modport slave (
    input  id_src, id_src_used, id_dest,
    input  id_ld_reg, id_is_load,
    input  i_stall, d_stall, redirect,
    output load_if, load_id_ex,
    output load_ex_mem, load_mem_wb,
    output valid_ex, valid_mem, valid_wb,
    output fwd_sel_ex, stall_load,
    output cnt_load_stall, cnt_flush, cnt_istall
  );
endinterface

// File: rtl/pipe_hazard_cmp.sv
// Per-source compare of the ID operand against EX/MEM records.
// Ports: src/used in; ex/mem records in; m_ex_ld, m_mem_ld, fwd_sel out.
module pipe_hazard_cmp
  import lc3b_types::*;
#(
  parameter int REG_W = LC3B_REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  stage_rec_t       ex,
  input  stage_rec_t       mem,
  output logic             m_ex_ld,
  output logic             m_mem_ld,
  output fwd_sel_t         fwd_sel
);

  logic hit_ex;
  logic hit_mem;

  always_comb begin
    hit_ex   = used && ex.v && ex.ld_reg &&
               (src == ex.dest);
    hit_mem  = used && mem.v && mem.ld_reg &&
               (src == mem.dest);
    m_ex_ld  = hit_ex && ex.is_load;
    m_mem_ld = hit_mem && mem.is_load;
    // A load in EX has no result yet; fall to MEM.
    fwd_sel  = FWD_RF;
    if (hit_ex && !ex.is_load) begin
      fwd_sel = FWD_MEM;
    end else if (hit_mem) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: valids, stage enables,
// EX forwarding selects, load-use bubbles, stalls, flush, counters.
// Ports: clk, reset (sync, active-high), bus (pipe_ctrl_if.slave).
module pipe_ctrl
  import lc3b_types::*;
#(
  parameter int REG_W    = 3,
  parameter int NSRC     = 2,
  parameter int CNT_W    = 32,
  parameter int LOAD_FWD = 1
) (
  input logic        clk,
  input logic        reset,
  pipe_ctrl_if.slave bus
);

  stage_rec_t        id_rec;
  stage_rec_t        ex_q, ex_d;
  stage_rec_t        mem_q, mem_d;
  logic              v_id_q, v_id_d;
  logic              v_wb_q, v_wb_d;
  pipe_state_t       state_q, state_d;
  logic [2*NSRC-1:0] fwd_q, fwd_d, fwd_calc;
  logic [NSRC-1:0]   m_ex_ld, m_mem_ld;
  logic [CNT_W-1:0]  cnt_ls_q, cnt_ls_d;
  logic [CNT_W-1:0]  cnt_fl_q, cnt_fl_d;
  logic [CNT_W-1:0]  cnt_is_q, cnt_is_d;
  logic              redir, haz;
  logic              ld_if, ld_idex;
  logic              ld_exmem, ld_memwb;
  logic              stall_ld;

  for (genvar k = 0; k < NSRC; k++) begin : g_cmp
    fwd_sel_t sel;
    pipe_hazard_cmp #(.REG_W(REG_W)) u_cmp (
      .src     (bus.id_src[k*REG_W +: REG_W]),
      .used    (bus.id_src_used[k]),
      .ex      (ex_q),
      .mem     (mem_q),
      .m_ex_ld (m_ex_ld[k]),
      .m_mem_ld(m_mem_ld[k]),
      .fwd_sel (sel)
    );
    assign fwd_calc[2*k +: 2] = sel;
  end

  always_comb begin
    id_rec   = '{v: v_id_q, dest: bus.id_dest,
                 ld_reg: bus.id_ld_reg,
                 is_load: bus.id_is_load};
    redir    = bus.redirect && v_wb_q;
    haz      = v_id_q && ((|m_ex_ld) ||
               ((LOAD_FWD == 0) && (|m_mem_ld)));

    v_id_d   = v_id_q;
    ex_d     = ex_q;
    mem_d    = mem_q;
    v_wb_d   = v_wb_q;
    state_d  = state_q;
    fwd_d    = fwd_q;
    cnt_ls_d = cnt_ls_q;
    cnt_fl_d = cnt_fl_q;
    cnt_is_d = cnt_is_q;
    ld_if    = 1'b0;
    ld_idex  = 1'b0;
    ld_exmem = 1'b0;
    ld_memwb = 1'b0;
    stall_ld = 1'b0;

    if (reset || bus.d_stall) begin
      // everything frozen
    end else if (redir) begin
      ld_if    = 1'b1;
      ld_idex  = 1'b1;
      ld_exmem = 1'b1;
      ld_memwb = 1'b1;
      v_id_d   = 1'b0;
      ex_d     = id_rec;
      ex_d.v   = 1'b0;
      mem_d    = ex_q;
      mem_d.v  = 1'b0;
      v_wb_d   = 1'b0;
      fwd_d    = '0;
      cnt_fl_d = cnt_fl_q + CNT_W'(1);
      // An in-flight fetch will return wrong-path data.
      state_d  = bus.i_stall ? DISCARD : RUN;
    end else if (haz) begin
      ld_idex  = 1'b1;
      ld_exmem = 1'b1;
      ld_memwb = 1'b1;
      ex_d     = '0;
      mem_d    = ex_q;
      v_wb_d   = mem_q.v;
      fwd_d    = '0;
      stall_ld = 1'b1;
      cnt_ls_d = cnt_ls_q + CNT_W'(1);
    end else if (bus.i_stall) begin
      ld_idex  = 1'b1;
      ld_exmem = 1'b1;
      ld_memwb = 1'b1;
      ex_d     = id_rec;
      mem_d    = ex_q;
      v_wb_d   = mem_q.v;
      fwd_d    = fwd_calc;
      v_id_d   = 1'b0;
      cnt_is_d = cnt_is_q + CNT_W'(1);
    end else begin
      ld_if    = 1'b1;
      ld_idex  = 1'b1;
      ld_exmem = 1'b1;
      ld_memwb = 1'b1;
      ex_d     = id_rec;
      mem_d    = ex_q;
      v_wb_d   = mem_q.v;
      fwd_d    = fwd_calc;
      v_id_d   = (state_q == RUN);
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_id_q   <= 1'b0;
      ex_q     <= '0;
      mem_q    <= '0;
      v_wb_q   <= 1'b0;
      state_q  <= RUN;
      fwd_q    <= '0;
      cnt_ls_q <= '0;
      cnt_fl_q <= '0;
      cnt_is_q <= '0;
    end else begin
      v_id_q   <= v_id_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      v_wb_q   <= v_wb_d;
      state_q  <= state_d;
      fwd_q    <= fwd_d;
      cnt_ls_q <= cnt_ls_d;
      cnt_fl_q <= cnt_fl_d;
      cnt_is_q <= cnt_is_d;
    end
  end

  assign bus.load_if        = ld_if;
  assign bus.load_id_ex     = ld_idex;
  assign bus.load_ex_mem    = ld_exmem;
  assign bus.load_mem_wb    = ld_memwb;
  assign bus.valid_ex       = ex_q.v;
  assign bus.valid_mem      = mem_q.v;
  assign bus.valid_wb       = v_wb_q;
  assign bus.fwd_sel_ex     = fwd_q;
  assign bus.stall_load     = stall_ld;
  assign bus.cnt_load_stall = cnt_ls_q;
  assign bus.cnt_flush      = cnt_fl_q;
  assign bus.cnt_istall     = cnt_is_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances,
// LOAD_FWD=1 (dut_a) and LOAD_FWD=0 (dut_b), sharing inputs.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_W(3), .NSRC(2), .CNT_W(32)) ifa ();
  pipe_ctrl_if #(.REG_W(3), .NSRC(2), .CNT_W(32)) ifb ();

  assign ifb.id_src      = ifa.id_src;
  assign ifb.id_src_used = ifa.id_src_used;
  assign ifb.id_dest     = ifa.id_dest;
  assign ifb.id_ld_reg   = ifa.id_ld_reg;
  assign ifb.id_is_load  = ifa.id_is_load;
  assign ifb.i_stall     = ifa.i_stall;
  assign ifb.d_stall     = ifa.d_stall;
  assign ifb.redirect    = ifa.redirect;

  pipe_ctrl #(.REG_W(3), .NSRC(2), .CNT_W(32),
              .LOAD_FWD(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));

  pipe_ctrl #(.REG_W(3), .NSRC(2), .CNT_W(32),
              .LOAD_FWD(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  function automatic logic [3:0] loads_a();
    return {ifa.load_if, ifa.load_id_ex,
            ifa.load_ex_mem, ifa.load_mem_wb};
  endfunction

  function automatic logic [2:0] valids_a();
    return {ifa.valid_ex, ifa.valid_mem, ifa.valid_wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [2:0] s0,
                        input logic [2:0] s1,
                        input logic [1:0] u,
                        input logic [2:0] d,
                        input logic lr,
                        input logic ld);
    ifa.id_src      = {s1, s0};
    ifa.id_src_used = u;
    ifa.id_dest     = d;
    ifa.id_ld_reg   = lr;
    ifa.id_is_load  = ld;
    #1;
  endtask

  task automatic nop();
    set_id(3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_seq();
    reset = 1'b1;
    ifa.i_stall = 1'b0;
    ifa.d_stall = 1'b0;
    ifa.redirect = 1'b0;
    nop();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.i_stall = 1'b0;
    ifa.d_stall = 1'b0;
    ifa.redirect = 1'b0;
    nop();
    tick();
    tick();
    n_cmp++;
    if (loads_a() !== 4'h0 || ifb.load_if !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_loads: got %h want 0", loads_a());
    end
    n_cmp++;
    if (valids_a() !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_valid: got %b want 000", valids_a());
    end
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h0 || ifa.stall_load !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_fwd: got %h/%b want 0/0",
               ifa.fwd_sel_ex, ifa.stall_load);
    end
    n_cmp++;
    if ({ifa.cnt_load_stall, ifa.cnt_flush,
         ifa.cnt_istall} !== 96'h0) begin
      n_bad++;
      $display("FAIL rst_cnt: got %0d %0d %0d want 0",
               ifa.cnt_load_stall, ifa.cnt_flush, ifa.cnt_istall);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_fwd();
    reset_seq();
    set_id(3'd5, 3'd6, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    n_cmp++;
    if (ifa.stall_load !== 1'b0 || ifb.stall_load !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_nostall: got %b/%b want 0/0",
               ifa.stall_load, ifb.stall_load);
    end
    tick();
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h5 || ifb.fwd_sel_ex !== 4'h5) begin
      n_bad++;
      $display("FAIL alu_fwd_ex: got %h/%h want 5",
               ifa.fwd_sel_ex, ifb.fwd_sel_ex);
    end
    set_id(3'd2, 3'd1, 2'b10, 3'd2, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h8) begin
      n_bad++;
      $display("FAIL alu_fwd_mem_unused: got %h want 8",
               ifa.fwd_sel_ex);
    end
    set_id(3'd2, 3'd2, 2'b01, 3'd0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h1) begin
      n_bad++;
      $display("FAIL alu_ex_prio: got %h want 1", ifa.fwd_sel_ex);
    end
    set_id(3'd0, 3'd0, 2'b11, 3'd3, 1'b0, 1'b0);
    n_cmp++;
    if (ifa.stall_load !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_r0_nostall: got %b want 0", ifa.stall_load);
    end
    tick();
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h5 || valids_a() !== 3'b111) begin
      n_bad++;
      $display("FAIL alu_r0_fwd: got %h/%b want 5/111",
               ifa.fwd_sel_ex, valids_a());
    end
  endtask

  task automatic test_load_use();
    reset_seq();
    set_id(3'd6, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1);
    tick();
    set_id(3'd3, 3'd0, 2'b11, 3'd4, 1'b1, 1'b0);
    n_cmp++;
    if (ifa.stall_load !== 1'b1 || ifb.stall_load !== 1'b1 ||
        loads_a() !== 4'b0111) begin
      n_bad++;
      $display("FAIL lu_bubble1: got %b/%b %b want 1/1 0111",
               ifa.stall_load, ifb.stall_load, loads_a());
    end
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b0 || ifb.valid_ex !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_vex_bubble: got %b/%b want 0/0",
               ifa.valid_ex, ifb.valid_ex);
    end
    n_cmp++;
    if (ifa.stall_load !== 1'b0 || ifb.stall_load !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_bubble2: got %b/%b want 0/1",
               ifa.stall_load, ifb.stall_load);
    end
    tick();
    n_cmp++;
    if (ifa.fwd_sel_ex !== 4'h2 || ifa.valid_ex !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_fwd_a: got %h/%b want 2/1",
               ifa.fwd_sel_ex, ifa.valid_ex);
    end
    n_cmp++;
    if (ifa.cnt_load_stall !== 32'd1 ||
        ifb.cnt_load_stall !== 32'd2) begin
      n_bad++;
      $display("FAIL lu_cnt: got %0d/%0d want 1/2",
               ifa.cnt_load_stall, ifb.cnt_load_stall);
    end
    n_cmp++;
    if (ifb.valid_ex !== 1'b0 || ifb.stall_load !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_b_after: got %b/%b want 0/0",
               ifb.valid_ex, ifb.stall_load);
    end
    tick();
    n_cmp++;
    if (ifb.fwd_sel_ex !== 4'h0 || ifb.valid_ex !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_fwd_b: got %h/%b want 0/1",
               ifb.fwd_sel_ex, ifb.valid_ex);
    end
    nop();
  endtask

  task automatic test_dstall();
    reset_seq();
    set_id(3'd6, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1);
    tick();
    ifa.d_stall = 1'b1;
    set_id(3'd3, 3'd0, 2'b11, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (loads_a() !== 4'h0 || ifa.stall_load !== 1'b0) begin
        n_bad++;
        $display("FAIL ds_hold%0d: got %h/%b want 0/0",
                 i, loads_a(), ifa.stall_load);
      end
      tick();
    end
    n_cmp++;
    if (ifa.cnt_load_stall !== 32'd0 || ifa.valid_ex !== 1'b1) begin
      n_bad++;
      $display("FAIL ds_frozen: got %0d/%b want 0/1",
               ifa.cnt_load_stall, ifa.valid_ex);
    end
    ifa.d_stall = 1'b0;
    #1;
    n_cmp++;
    if (ifa.stall_load !== 1'b1) begin
      n_bad++;
      $display("FAIL ds_release: got %b want 1", ifa.stall_load);
    end
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b0 || ifa.cnt_load_stall !== 32'd1) begin
      n_bad++;
      $display("FAIL ds_bubble: got %b/%0d want 0/1",
               ifa.valid_ex, ifa.cnt_load_stall);
    end
    nop();
  endtask

  task automatic test_redirect();
    reset_seq();
    ifa.redirect = 1'b1;
    nop();
    tick();
    ifa.redirect = 1'b0;
    n_cmp++;
    if (ifa.cnt_flush !== 32'd0) begin
      n_bad++;
      $display("FAIL rd_gated: got %0d want 0", ifa.cnt_flush);
    end
    tick();
    tick();
    n_cmp++;
    if (valids_a() !== 3'b111) begin
      n_bad++;
      $display("FAIL rd_fill: got %b want 111", valids_a());
    end
    ifa.redirect = 1'b1;
    ifa.i_stall = 1'b1;
    #1;
    n_cmp++;
    if (loads_a() !== 4'hf) begin
      n_bad++;
      $display("FAIL rd_loads: got %h want f", loads_a());
    end
    tick();
    ifa.redirect = 1'b0;
    #1;
    n_cmp++;
    if (valids_a() !== 3'b000 || ifa.cnt_flush !== 32'd1) begin
      n_bad++;
      $display("FAIL rd_flush: got %b/%0d want 000/1",
               valids_a(), ifa.cnt_flush);
    end
    n_cmp++;
    if (loads_a() !== 4'b0111) begin
      n_bad++;
      $display("FAIL rd_istall: got %b want 0111", loads_a());
    end
    tick();
    tick();
    ifa.i_stall = 1'b0;
    #1;
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_t1: got %b want 0", ifa.valid_ex);
    end
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_discard: got %b want 0", ifa.valid_ex);
    end
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b1 || ifa.cnt_istall !== 32'd2 ||
        ifa.cnt_flush !== 32'd1) begin
      n_bad++;
      $display("FAIL rd_resume: got %b/%0d/%0d want 1/2/1",
               ifa.valid_ex, ifa.cnt_istall, ifa.cnt_flush);
    end
  endtask

  task automatic test_reset_mid();
    set_id(3'd5, 3'd6, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(3'd1, 3'd1, 2'b11, 3'd5, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (valids_a() !== 3'b111 || ifa.fwd_sel_ex !== 4'h5) begin
      n_bad++;
      $display("FAIL mr_pre: got %b/%h want 111/5",
               valids_a(), ifa.fwd_sel_ex);
    end
    reset = 1'b1;
    nop();
    n_cmp++;
    if (loads_a() !== 4'h0) begin
      n_bad++;
      $display("FAIL mr_loads: got %h want 0", loads_a());
    end
    tick();
    reset = 1'b0;
    n_cmp++;
    if (valids_a() !== 3'b000 || ifa.fwd_sel_ex !== 4'h0) begin
      n_bad++;
      $display("FAIL mr_state: got %b/%h want 000/0",
               valids_a(), ifa.fwd_sel_ex);
    end
    n_cmp++;
    if ({ifa.cnt_load_stall, ifa.cnt_flush,
         ifa.cnt_istall} !== 96'h0) begin
      n_bad++;
      $display("FAIL mr_cnt: got %0d %0d %0d want 0",
               ifa.cnt_load_stall, ifa.cnt_flush, ifa.cnt_istall);
    end
    tick();
    tick();
    n_cmp++;
    if (ifa.valid_ex !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_run: got %b want 1", ifa.valid_ex);
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_dstall();
    test_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
